alu_seq: RTL

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Operates at WIDTH bits, with valid/ready handshakes on input and output.
- Produces a double-width result for MUL and a quotient/remainder pair for DIV, using an iterative divider.
- Sits between the register file read ports and the writeback mux. The control FSM stalls on in_ready/out_valid instead of assuming one-cycle completion.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq_iter.sv | 97 +++++++++
 rtl/alu_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, status flags and FSM states.
package alu_seq_pkg;

    // Encoding is inherited from the single-cycle ALU and must not be reordered.
    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        DIV = 4'd3,
        SHL = 4'd4,
        ROL = 4'd5,
        SHR = 4'd6,
        ROR = 4'd7,
        AND = 4'd8,
        OR  = 4'd9,
        XOR = 4'd10,
        NOT = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        ZERO      = 3'd1,
        CARRY     = 3'd2,
        REMAINDER = 3'd3,
        DIVZERO   = 3'd4
    } alu_flag_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the register-file read side and writeback.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    import alu_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_e          op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    alu_flag_e        flag;

    // Master issues operations and consumes results; slave is the ALU.
    modport master (
        output in_valid, op, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, result_hi, flag
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, result_hi, flag
    );

endinterface

// File: rtl/alu_seq_iter.sv
// Iterative engine: restoring divider (MSB first) or shift-add multiplier (LSB first)
// sharing one accumulator/shift register pair. The first step runs on the start edge.
module alu_seq_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_acc_in;
    logic [WIDTH-1:0] w_q_in;
    logic [WIDTH-1:0] w_b_in;
    logic             w_mul;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0] w_q_step;

    // One iteration; on start it operates on the fresh operands instead of the registers.
    always_comb begin
        w_acc_in = start ? '0   : r_acc;
        w_q_in   = start ? a    : r_q;
        w_b_in   = start ? b    : r_b;
        w_mul    = start ? mode : r_mode;

        w_rem_sh = {w_acc_in, w_q_in[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, w_b_in};
        w_qbit   = ~w_diff[WIDTH];

        w_sum    = {1'b0, w_acc_in} + (w_q_in[0] ? {1'b0, w_b_in} : '0);

        if (w_mul) begin
            w_acc_step = w_sum[WIDTH:1];
            w_q_step   = {w_sum[0], w_q_in[WIDTH-1:1]};
        end else begin
            w_acc_step = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            w_q_step   = {w_q_in[WIDTH-2:0], w_qbit};
        end
    end

    // done pulses for one cycle after the WIDTH-th step has been written.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_b    <= '0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc  <= w_acc_step;
                r_q    <= w_q_step;
                r_b    <= b;
                r_mode <= mode;
                r_cnt  <= CNT_W'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_acc <= w_acc_step;
                r_q   <= w_q_step;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign lo   = r_q;
    assign hi   = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes. Define ALU_ITER_MUL_EN to run MUL on the
// iterative engine (WIDTH+1 latency) instead of an inferred single-cycle multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int unsigned WIDTH   = 8,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic      clock,
    input  logic      reset,
    alu_seq_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_EXEC = 2'(EXEC);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    alu_op_e          r_op;
    alu_op_e          w_op_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic [WIDTH-1:0] r_result_hi;
    logic [WIDTH-1:0] w_result_hi_nxt;
    alu_flag_e        r_flag;
    alu_flag_e        w_flag_nxt;

    logic [SHAMT_W-1:0] w_sh;
    logic [SHAMT_W:0]   w_inv;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_sc_lo;
    logic [WIDTH-1:0]   w_sc_hi;
    logic               w_sc_carry;
    logic               w_sc_divz;
    logic               w_needs_exec;
    logic               w_mode_mul;
    logic               w_start;
    logic               w_eng_busy;
    logic               w_eng_done;
    logic [WIDTH-1:0]   w_eng_lo;
    logic [WIDTH-1:0]   w_eng_hi;

`ifndef ALU_ITER_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = (2*WIDTH)'(bus.operand_a) * (2*WIDTH)'(bus.operand_b);
`endif

    function automatic alu_flag_e flag_of(input alu_op_e op, input logic [WIDTH-1:0] lo,
                                          input logic hi_nz, input logic carry,
                                          input logic divz);
        if (divz)                                          return DIVZERO;
        if (lo == '0)                                      return ZERO;
        if (carry && (op == ADD || op == SUB || op == MUL)) return CARRY;
        if (op == DIV && hi_nz)                            return REMAINDER;
        return NONE;
    endfunction

    // Single-cycle datapath evaluated straight from the request bus.
    always_comb begin
        w_sh       = bus.operand_b[SHAMT_W-1:0];
        w_inv      = (SHAMT_W+1)'(WIDTH) - (SHAMT_W+1)'(w_sh);
        w_sum      = (WIDTH+1)'(bus.operand_a) + (WIDTH+1)'(bus.operand_b);
        w_diff     = (WIDTH+1)'(bus.operand_a) - (WIDTH+1)'(bus.operand_b);
        w_sc_lo    = '0;
        w_sc_hi    = '0;
        w_sc_carry = 1'b0;
        w_sc_divz  = 1'b0;
        case (bus.op)
            ADD: begin
                w_sc_lo    = w_sum[WIDTH-1:0];
                w_sc_carry = w_sum[WIDTH];
            end
            SUB: begin
                w_sc_lo    = w_diff[WIDTH-1:0];
                w_sc_carry = w_diff[WIDTH];
            end
`ifndef ALU_ITER_MUL_EN
            MUL: begin
                w_sc_lo    = w_prod[WIDTH-1:0];
                w_sc_hi    = w_prod[2*WIDTH-1:WIDTH];
                w_sc_carry = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            // Only reached with a zero divisor; nonzero divisors go to the engine.
            DIV: begin
                w_sc_lo   = '1;
                w_sc_hi   = bus.operand_a;
                w_sc_divz = 1'b1;
            end
            SHL: w_sc_lo = bus.operand_a << w_sh;
            SHR: w_sc_lo = bus.operand_a >> w_sh;
            ROL: w_sc_lo = (bus.operand_a << w_sh) | (bus.operand_a >> w_inv);
            ROR: w_sc_lo = (bus.operand_a >> w_sh) | (bus.operand_a << w_inv);
            AND: w_sc_lo = bus.operand_a & bus.operand_b;
            OR:  w_sc_lo = bus.operand_a | bus.operand_b;
            XOR: w_sc_lo = bus.operand_a ^ bus.operand_b;
            NOT: w_sc_lo = ~bus.operand_a;
            default: begin
                w_sc_lo = '0;
                w_sc_hi = '0;
            end
        endcase
    end

`ifdef ALU_ITER_MUL_EN
    assign w_mode_mul   = (bus.op == MUL);
    assign w_needs_exec = (bus.op == DIV && bus.operand_b != '0) || (bus.op == MUL);
`else
    assign w_mode_mul   = 1'b0;
    assign w_needs_exec = (bus.op == DIV && bus.operand_b != '0);
`endif

    // Next-state and registered-output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;
        w_result_nxt    = r_result;
        w_result_hi_nxt = r_result_hi;
        w_flag_nxt      = r_flag;
        w_start         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_op_nxt       = bus.op;
                    w_in_ready_nxt = 1'b0;
                    if (w_needs_exec) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt     = ST_DONE;
                        w_out_valid_nxt = 1'b1;
                        w_result_nxt    = w_sc_lo;
                        w_result_hi_nxt = w_sc_hi;
                        w_flag_nxt      = flag_of(bus.op, w_sc_lo, |w_sc_hi, w_sc_carry,
                                                  w_sc_divz);
                    end
                end
            end
            ST_EXEC: begin
                if (w_eng_done) begin
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b1;
                    w_result_nxt    = w_eng_lo;
                    w_result_hi_nxt = w_eng_hi;
                    w_flag_nxt      = flag_of(r_op, w_eng_lo, |w_eng_hi,
                                              (r_op == MUL) && (|w_eng_hi), 1'b0);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= ADD;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flag      <= NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_result    <= w_result_nxt;
            r_result_hi <= w_result_hi_nxt;
            r_flag      <= w_flag_nxt;
        end
    end

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock (clock),
        .reset (reset),
        .start (w_start),
        .mode  (w_mode_mul),
        .a     (bus.operand_a),
        .b     (bus.operand_b),
        .busy  (w_eng_busy),
        .done  (w_eng_done),
        .lo    (w_eng_lo),
        .hi    (w_eng_hi)
    );

    // While waiting in EXEC the engine must still be running or just finishing.
    a_exec_engine_alive: assert property (@(posedge clock) disable iff (reset)
        (r_state == ST_EXEC) |-> (w_eng_busy || w_eng_done));

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.flag      = r_flag;

endmodule
